// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART framing constants and receiver state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int   c_UART_DATA_BITS  = 8;
   localparam logic c_UART_IDLE_LEVEL = 1'b1;
   localparam logic c_UART_STOP_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a single asynchronous input bit.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_receive.sv
`default_nettype none
// ============================================================================
// Module   : uart_receive
// Purpose  : 8N1 UART receiver, mid-bit sampling, valid/ready byte output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receive
   import uart_pkg::*;
#(
   parameter int INPUT_CLOCK_FREQ = 240_000_000,
   parameter int BAUD_RATE        = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       busy,
   output logic       framing_error,
   output logic       overrun
);

   localparam int c_BIT_PERIOD  = INPUT_CLOCK_FREQ / BAUD_RATE;
   localparam int c_HALF_PERIOD = c_BIT_PERIOD / 2;
   localparam int c_CNT_W       = (c_BIT_PERIOD > 1) ? $clog2(c_BIT_PERIOD) : 1;
   localparam int c_IDX_W       = $clog2(c_UART_DATA_BITS);

   localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_BIT_PERIOD - 1);
   localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF_PERIOD - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_UART_DATA_BITS - 1);

   logic                        w_rx_s;
   logic                        r_rx_prev;
   uart_rx_state_t              r_state;
   uart_rx_state_t              w_next_state;
   logic [c_CNT_W-1:0]          r_cnt;
   logic [c_IDX_W-1:0]          r_bit_idx;
   logic [c_UART_DATA_BITS-1:0] r_shift;
   logic [c_UART_DATA_BITS-1:0] r_dout;
   logic                        r_dout_valid;
   logic                        r_frame_err;
   logic                        r_overrun;

   logic w_start_edge;
   logic w_bit_tick;
   logic w_half_tick;
   logic w_cnt_run;
   logic w_cnt_clr;
   logic w_shift_en;
   logic w_byte_done;
   logic w_bad_stop;
   logic w_load;

   sync_2ff #(
      .RESET_VAL (c_UART_IDLE_LEVEL)
   ) u_sync_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (rxd),
      .o_q   (w_rx_s)
   );

   assign w_start_edge = r_rx_prev & ~w_rx_s;
   assign w_bit_tick   = (r_cnt == c_BIT_LAST);
   assign w_half_tick  = (r_cnt == c_HALF_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:      if (w_start_edge) w_next_state = ST_START;
         ST_START:     if (w_half_tick)  w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:      if (w_bit_tick && (r_bit_idx == c_IDX_LAST)) w_next_state = ST_STOP;
         ST_STOP:      if (w_bit_tick) begin
                          w_next_state = (w_rx_s == c_UART_STOP_LEVEL) ? ST_IDLE : ST_WAIT_HIGH;
                       end
         ST_WAIT_HIGH: if (w_rx_s) w_next_state = ST_IDLE;
         default:      w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_run   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_shift_en  = 1'b0;
      w_byte_done = 1'b0;
      w_bad_stop  = 1'b0;
      case (r_state)
         ST_START: begin
            w_cnt_run = 1'b1;
            w_cnt_clr = w_half_tick;
         end
         ST_DATA: begin
            w_cnt_run  = 1'b1;
            w_cnt_clr  = w_bit_tick;
            w_shift_en = w_bit_tick;
         end
         ST_STOP: begin
            w_cnt_run   = 1'b1;
            w_cnt_clr   = w_bit_tick;
            w_byte_done = w_bit_tick & (w_rx_s == c_UART_STOP_LEVEL);
            w_bad_stop  = w_bit_tick & (w_rx_s != c_UART_STOP_LEVEL);
         end
         default: begin
            w_cnt_clr = 1'b1;
         end
      endcase
   end

   // A finished byte may only replace dout if the previous one is gone or leaving now.
   assign w_load = w_byte_done & (~r_dout_valid | dout_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_prev    <= c_UART_IDLE_LEVEL;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_rx_prev <= w_rx_s;

         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_run) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (r_state != ST_DATA) begin
            r_bit_idx <= '0;
         end else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + 1'b1;
         end

         if (w_shift_en) begin
            r_shift <= {w_rx_s, r_shift[c_UART_DATA_BITS-1:1]};
         end

         if (w_load) begin
            r_dout       <= r_shift;
            r_dout_valid <= 1'b1;
         end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
         end

         r_frame_err <= w_bad_stop;
         r_overrun   <= w_byte_done & r_dout_valid & ~dout_ready;
      end
   end

   assign dout          = r_dout;
   assign dout_valid    = r_dout_valid;
   assign busy          = (r_state != ST_IDLE);
   assign framing_error = r_frame_err;
   assign overrun       = r_overrun;

endmodule : uart_receive
`default_nettype wire

// File: tb/tb_uart_receive.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receive
// Purpose  : Scoreboard bench for uart_receive at 16 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receive;

   localparam int c_CLK_HZ = 16;
   localparam int c_BAUD   = 1;
   localparam int c_BIT    = 16;

   logic       clk;
   logic       rst_n;
   logic       rxd;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       busy;
   logic       framing_error;
   logic       overrun;

   int         n_checks;
   int         n_fail;
   int         fe_cnt;
   int         ov_cnt;
   logic [7:0] exp_q[$];

   uart_receive #(
      .INPUT_CLOCK_FREQ (c_CLK_HZ),
      .BAUD_RATE        (c_BAUD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rxd           (rxd),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .dout_ready    (dout_ready),
      .busy          (busy),
      .framing_error (framing_error),
      .overrun       (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Line-side transmitter model: start, 8 data bits LSB first, stop.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rxd = 1'b0;
      repeat (c_BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (c_BIT) @(negedge clk);
      end
      rxd = stop;
      repeat (c_BIT) @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: pops the scoreboard on every accepted byte.
   initial begin
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no byte", dout);
            end else begin
               exp_b = exp_q.pop_front();
               check("dout_byte", 32'(dout), 32'(exp_b));
            end
         end
         if (framing_error) fe_cnt++;
         if (overrun)       ov_cnt++;
      end
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      fe_cnt     = 0;
      ov_cnt     = 0;
      rst_n      = 1'b0;
      rxd        = 1'b1;
      dout_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_dout",       32'(dout),          32'd0);
      check("reset_dout_valid", 32'(dout_valid),    32'd0);
      check("reset_busy",       32'(busy),          32'd0);
      check("reset_ferr",       32'(framing_error), 32'd0);
      check("reset_overrun",    32'(overrun),       32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Clean frame with consumer ready
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      repeat (4) @(negedge clk);
      wait_drain();
      check("a5_ferr_count", 32'(fe_cnt), 32'd0);
      check("a5_idle",       32'(busy),   32'd0);

      // Short low glitch: detected, then rejected at the half-bit sample
      @(negedge clk);
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      check("glitch_busy_seen", 32'(busy), 32'd1);
      repeat (6) @(negedge clk);
      check("glitch_busy_clear", 32'(busy), 32'd0);
      check("glitch_no_byte",    32'(dout_valid), 32'd0);

      // Bad stop bit followed by a long break
      send_frame(8'h3C, 1'b0);
      repeat (40) @(negedge clk);
      check("break_busy",       32'(busy),       32'd1);
      check("break_ferr_count", 32'(fe_cnt),     32'd1);
      check("break_no_byte",    32'(dout_valid), 32'd0);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      check("break_busy_clear", 32'(busy), 32'd0);

      // Back-to-back frames with the consumer stalled
      dout_ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (4) @(negedge clk);
      check("ovr_count",      32'(ov_cnt),     32'd1);
      check("ovr_dout_held",  32'(dout),       32'h11);
      check("ovr_valid_held", 32'(dout_valid), 32'd1);
      dout_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ovr_valid_clear", 32'(dout_valid), 32'd0);
      wait_drain();

      // Reset in the middle of a data phase
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (60) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("midrst_dout",    32'(dout),          32'd0);
            check("midrst_valid",   32'(dout_valid),    32'd0);
            check("midrst_busy",    32'(busy),          32'd0);
            check("midrst_ferr",    32'(framing_error), 32'd0);
            check("midrst_overrun", 32'(overrun),       32'd0);
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b1;
         end
      join
      repeat (20) @(negedge clk);
      check("midrst_idle", 32'(busy), 32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      wait_drain();

      // Loopback-style byte sequence
      exp_q.push_back(8'h00);
      send_frame(8'h00, 1'b1);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1);
      repeat (4) @(negedge clk);
      wait_drain();
      check("final_ferr_count", 32'(fe_cnt), 32'd1);
      check("final_ovr_count",  32'(ov_cnt), 32'd1);
      check("final_idle",       32'(busy),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_receive
`default_nettype wire
